fifo_sync: RTL and testbench
============================

Name:
fifo_sync

Overview:
- Single-clock synchronous FIFO. Parameterised data width and non-power-of-two depth.
- Write and read ports are independent, with FULL/EMPTY status flags.
- Used as a general buffer between a producer and a consumer in the same clock domain.
- Storage array is named mem so benches can preload or inspect it hierarchically.

Parameters:
- FIFO_WIDTH, 32, data word width in bits.
- FIFO_DEPTH, 45, number of storage entries; any value from 2 to 2^ADDR_SIZE is legal.
- ADDR_SIZE, 6, width of the read/write pointers; must satisfy 2^ADDR_SIZE >= FIFO_DEPTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- din  input  FIFO_WIDTH  write data.
- wen_a  input  1  write enable.
- ren_b  input  1  read enable.
- dout  output  FIFO_WIDTH  registered read data.
- FULL  output  1  high when the FIFO holds FIFO_DEPTH entries.
- EMPTY  output  1  high when the FIFO holds 0 entries.
- Positional port order is fixed: din, clk, rst, wen_a, ren_b, dout, FULL, EMPTY.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst low, any time, independent of clk):
  - write pointer, read pointer and occupancy count go to 0.
  - dout = 0, EMPTY = 1, FULL = 0.
  - mem contents are not cleared.
- State: mem[0:FIFO_DEPTH-1], wr_ptr and rd_ptr (ADDR_SIZE bits each), count (0..FIFO_DEPTH, ADDR_SIZE+1 bits).
- Flags are combinational decodes of count: FULL = (count == FIFO_DEPTH), EMPTY = (count == 0).
- Write accepted when wen_a=1 and FULL=0, evaluated before the edge:
  - mem[wr_ptr] <= din.
  - wr_ptr advances; it wraps from FIFO_DEPTH-1 to 0, not at 2^ADDR_SIZE.
- Write when FULL=1 is silently dropped: no pointer, count or mem change.
- Read accepted when ren_b=1 and EMPTY=0:
  - dout <= mem[rd_ptr]; rd_ptr advances with the same wrap rule.
  - Latency is 1 cycle: data appears on dout after the accepting edge.
- Read when EMPTY=1 is ignored; dout holds its last value.
- dout holds its value whenever no read is accepted.
- Count update:
  - +1 on accepted write only.
  - -1 on accepted read only.
  - unchanged when both or neither are accepted.
- Simultaneous wen_a and ren_b:
  - Not full and not empty: both accepted, count unchanged.
  - FULL: read accepted, write dropped; count becomes FIFO_DEPTH-1.
  - EMPTY: write accepted, read ignored; no first-word fall-through, and dout is not updated from the word being written.
- Ordering is strict FIFO; no overflow or underflow corruption of pointers.
- X on wen_a/ren_b while rst is low has no effect.

Test Plan:
- Reset, then idle -> EMPTY=1, FULL=0, dout=0. Assert rst low mid-stream -> flags return to EMPTY=1, FULL=0 immediately, without waiting for a clock edge.
- Overflow: after reset, 101 consecutive writes of din=0..100 ->
  - FULL rises after the 45th write (value 44).
  - Writes 45..100 are dropped; mem[0..44] = 0..44.
- Underflow: 51 consecutive reads after the fill ->
  - dout sequence 0..44, one per cycle after each accepting edge.
  - EMPTY after the 45th read.
  - The remaining 6 reads leave dout=44 and the pointers unchanged.
- Wrap-around: refill with 101 writes of 0..100, read 20, write 20 more (0..19), then drain ->
  - Output is 20..44 then 0..19.
  - Pointers wrap at 44 -> 0; FULL/EMPTY are correct throughout.
- Simultaneous read+write:
  - At FULL: count goes to 44 and the read word is correct.
  - At EMPTY: count goes to 1 and dout is unchanged.
  - Mid-level: count is constant across 26 cycles of concurrent traffic.
- Preload: $readmemh into mem with pointers at reset, then 45 writes of 0..44 followed by 26 reads -> dout returns 0..25 (writes overwrite preload), and EMPTY stays 0.

Source files
------------

// File: rtl/fifo_sync.sv
// Single-clock FIFO with a non-power-of-two depth, registered read data and
// FULL/EMPTY flags decoded from an explicit occupancy count.
module fifo_sync #(
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_DEPTH = 45,
  parameter int ADDR_SIZE  = 6
) (
  input  logic [FIFO_WIDTH-1:0] din,
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen_a,
  input  logic                  ren_b,
  output logic [FIFO_WIDTH-1:0] dout,
  output logic                  FULL,
  output logic                  EMPTY
);

  localparam logic [ADDR_SIZE-1:0] LAST_IDX  = ADDR_SIZE'(FIFO_DEPTH - 1);
  localparam logic [ADDR_SIZE:0]   DEPTH_CNT = (ADDR_SIZE + 1)'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [0:FIFO_DEPTH-1];

  logic [ADDR_SIZE-1:0] r_wr_ptr;
  logic [ADDR_SIZE-1:0] r_rd_ptr;
  logic [ADDR_SIZE:0]   r_count;

  logic w_wr_acc;
  logic w_rd_acc;

  assign FULL     = (r_count == DEPTH_CNT);
  assign EMPTY    = (r_count == '0);
  assign w_wr_acc = wen_a & ~FULL;
  assign w_rd_acc = ren_b & ~EMPTY;

  // Pointers wrap at the last real entry, not at the pointer's natural width.
  function automatic logic [ADDR_SIZE-1:0] ptr_next(input logic [ADDR_SIZE-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // NOTE: the storage array has no reset; clearing it would turn a RAM into
  // a huge flop bank, and the valid window is fully defined by the pointers.
  always_ff @(posedge clk) begin
    if (w_wr_acc) mem[r_wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      dout     <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_rd_acc) begin
        dout     <= mem[r_rd_ptr];
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync: a queue-based reference model checks every cycle of
// directed, table-driven and random traffic.
module tb_fifo_sync;

  localparam int W     = 32;
  localparam int DEPTH = 45;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         wen_a = 1'b0;
  logic         ren_b = 1'b0;
  logic [W-1:0] dout;
  logic         FULL;
  logic         EMPTY;

  fifo_sync #(.FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH), .ADDR_SIZE(6)) dut (
    .din(din), .clk(clk), .rst(rst), .wen_a(wen_a), .ren_b(ren_b),
    .dout(dout), .FULL(FULL), .EMPTY(EMPTY)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] exp_dout = '0;

  typedef struct {
    bit           w;
    bit           r;
    logic [W-1:0] d;
    bit           exp_full;
    bit           exp_empty;
    logic [W-1:0] exp_dout;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " dout"},  dout, exp_dout);
    check({tag, " FULL"},  W'(FULL),  W'(q.size() == DEPTH));
    check({tag, " EMPTY"}, W'(EMPTY), W'(q.size() == 0));
    check({tag, " count"}, W'(dut.r_count), W'(q.size()));
  endtask

  // One clock: drive on the falling edge, advance the model, sample 1ns after the rising edge.
  task automatic step(input bit w, input bit r, input logic [W-1:0] d, input string tag);
    bit wr_ok, rd_ok;
    @(negedge clk);
    wen_a = w; ren_b = r; din = d;
    wr_ok = w && (q.size() < DEPTH);
    rd_ok = r && (q.size() > 0);
    @(posedge clk);
    #1;
    if (rd_ok) exp_dout = q.pop_front();
    if (wr_ok) q.push_back(d);
    check_model(tag);
    wen_a = 1'b0; ren_b = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    q.delete();
    exp_dout = '0;
    check("async rst EMPTY", W'(EMPTY), W'(1));
    check("async rst FULL",  W'(FULL),  W'(0));
    check("async rst dout",  dout, '0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    vecs[0] = '{1, 0, 32'h11, 0, 0, 32'h00};
    vecs[1] = '{1, 1, 32'h22, 0, 0, 32'h11};
    vecs[2] = '{0, 1, 32'h00, 0, 1, 32'h22};
    vecs[3] = '{0, 1, 32'h00, 0, 1, 32'h22};
    vecs[4] = '{1, 1, 32'h33, 0, 0, 32'h22};
    vecs[5] = '{0, 1, 32'h00, 0, 1, 32'h33};

    // Reset with X on the enables must be harmless.
    wen_a = 1'bx; ren_b = 1'bx;
    #12;
    check("reset EMPTY", W'(EMPTY), W'(1));
    check("reset FULL",  W'(FULL),  W'(0));
    check("reset dout",  dout, '0);
    wen_a = 1'b0; ren_b = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, '0, "idle");

    for (int i = 0; i < 6; i++) begin
      step(vecs[i].w, vecs[i].r, vecs[i].d, $sformatf("vec%0d", i));
      check($sformatf("vec%0d tbl dout", i),  dout, vecs[i].exp_dout);
      check($sformatf("vec%0d tbl FULL", i),  W'(FULL),  W'(vecs[i].exp_full));
      check($sformatf("vec%0d tbl EMPTY", i), W'(EMPTY), W'(vecs[i].exp_empty));
    end

    // Overflow: only 0..44 are stored.
    do_reset();
    for (int i = 0; i <= 100; i++) begin
      step(1, 0, W'(i), $sformatf("ovf%0d", i));
      if (i == 43) check("not full at 44 words", W'(FULL), W'(0));
      if (i == 44) check("full at 45 words", W'(FULL), W'(1));
    end
    for (int i = 0; i < DEPTH; i++) check($sformatf("mem[%0d]", i), dut.mem[i], W'(i));

    // Underflow: 0..44 out, then reads are ignored.
    for (int i = 0; i < 51; i++) begin
      step(0, 1, '0, $sformatf("unf%0d", i));
      if (i < DEPTH) check($sformatf("unf%0d value", i), dout, W'(i));
      if (i == 44) check("empty after 45 reads", W'(EMPTY), W'(1));
    end
    check("unf hold dout", dout, W'(44));
    check("unf rd_ptr", W'(dut.r_rd_ptr), W'(0));
    check("unf wr_ptr", W'(dut.r_wr_ptr), W'(0));

    // Wrap-around.
    for (int i = 0; i <= 100; i++) step(1, 0, W'(i), "wrap fill");
    for (int i = 0; i < 20; i++) step(0, 1, '0, "wrap rd20");
    for (int i = 0; i < 20; i++) step(1, 0, W'(i), "wrap wr20");
    check("wrap wr_ptr", W'(dut.r_wr_ptr), W'(20));
    check("wrap FULL", W'(FULL), W'(1));
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, '0, "wrap drain");
      check($sformatf("wrap out%0d", i), dout, (i < 25) ? W'(20 + i) : W'(i - 25));
    end

    // Simultaneous at EMPTY: write only, dout unchanged.
    step(1, 1, 32'hABCD, "sim empty");
    check("sim empty count", W'(dut.r_count), W'(1));
    check("sim empty dout", dout, W'(19));

    // Simultaneous at FULL: read only.
    for (int i = 1; i < DEPTH; i++) step(1, 0, W'(100 + i), "sim fill");
    step(1, 1, 32'hDEAD, "sim full");
    check("sim full count", W'(dut.r_count), W'(44));
    check("sim full dout", dout, 32'hABCD);

    // Asynchronous reset from FULL-1/FULL state, no clock edge needed.
    step(1, 0, 32'h5, "refill");
    check("pre rst FULL", W'(FULL), W'(1));
    do_reset();

    // Mid-level concurrent traffic keeps count constant.
    for (int i = 0; i < 20; i++) step(1, 0, W'(200 + i), "mid fill");
    for (int i = 0; i < 26; i++) begin
      step(1, 1, W'(300 + i), "mid rw");
      check("mid count const", W'(dut.r_count), W'(20));
    end

    // Stale memory contents are overwritten by fresh writes after reset.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 0, W'(i), "pre wr");
    for (int i = 0; i < 26; i++) begin
      step(0, 1, '0, "pre rd");
      check($sformatf("pre rd%0d", i), dout, W'(i));
      check("pre EMPTY low", W'(EMPTY), W'(0));
    end

    // Random traffic against the queue model.
    for (int i = 0; i < 2000; i++) begin
      bit w, r;
      w = ($urandom_range(0, 99) < ((i / 500) % 2 ? 70 : 40));
      r = ($urandom_range(0, 99) < ((i / 500) % 2 ? 40 : 70));
      step(w, r, $urandom, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
